prog_rom: RTL



---
 rtl/cpu_pkg.sv | 57 +++++
 rtl/rom_read_pipe.sv | 54 +++++
 rtl/prog_rom.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction layout, opcode/mode codes, bus device
// codes and the instruction-store state encoding.
package cpu_pkg;

   localparam int INSTR_W = 14;

   // One instruction word: opcode[13:10], mode[9:8], op0[7:4], op1[3:0].
   typedef struct packed {
      logic [3:0] opcode;
      logic [1:0] mode;
      logic [3:0] op0;
      logic [3:0] op1;
   } instr_t;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_MOV  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_LD   = 4'h7;
   localparam logic [3:0] OP_ST   = 4'h8;
   localparam logic [3:0] OP_JMP  = 4'h9;
   localparam logic [3:0] OP_JZ   = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [1:0] MODE_REG = 2'd0;
   localparam logic [1:0] MODE_IMM = 2'd1;
   localparam logic [1:0] MODE_DIR = 2'd2;
   localparam logic [1:0] MODE_IND = 2'd3;

   localparam logic [1:0] DEV_ROM  = 2'b11;
   localparam instr_t     NOP_WORD = '0;

   typedef enum logic [1:0] {
      ROM_CLEAR = 2'd0,
      ROM_LOAD  = 2'd1,
      ROM_RUN   = 2'd2
   } rom_state_e;

   // Address width for a store of the given depth, never below one bit.
   function automatic int addr_bits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic instr_t make_instr(input logic [3:0] opcode, input logic [1:0] mode,
                                         input logic [3:0] op0, input logic [3:0] op1);
      instr_t w;
      w.opcode = opcode;
      w.mode   = mode;
      w.op0    = op0;
      w.op1    = op1;
      return w;
   endfunction

endpackage

// File: rtl/rom_read_pipe.sv
// Fixed-latency response pipe: carries valid/err/data of each accepted fetch
// through READ_LAT register stages. Reset drops everything in flight.
module rom_read_pipe #(
   parameter int WORD_W   = 14,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_err,
   input  logic [WORD_W-1:0] in_data,
   output logic              out_valid,
   output logic              out_err,
   output logic [WORD_W-1:0] out_data
);

   logic [READ_LAT-1:0] valid_q, valid_d;
   logic [READ_LAT-1:0] err_q, err_d;
   logic [WORD_W-1:0]   data_q [READ_LAT];
   logic [WORD_W-1:0]   data_d [READ_LAT];

   // Shift: stage 0 takes the new fetch, later stages take their predecessor.
   always_comb begin
      valid_d[0] = in_valid;
      err_d[0]   = in_err;
      data_d[0]  = in_data;
      for (int i = 1; i < READ_LAT; i++) begin
         valid_d[i] = valid_q[i-1];
         err_d[i]   = err_q[i-1];
         data_d[i]  = data_q[i-1];
      end
   end

   // Pipe registers; data is cleared too so the idle bus value is always zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         err_q   <= '0;
         for (int i = 0; i < READ_LAT; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         // NOTE: state registers use non-blocking assignments so every stage samples its predecessor's old value.
         valid_q <= valid_d;
         err_q   <= err_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q[READ_LAT-1];
   assign out_err   = err_q[READ_LAT-1];
   assign out_data  = data_q[READ_LAT-1];

endmodule

// File: rtl/prog_rom.sv
// Loadable instruction store. After reset it zero-fills itself (CLEAR),
// accepts a program image (LOAD), then serves fetches read-only (RUN).
module prog_rom
   import cpu_pkg::*;
#(
   parameter int         WORD_W   = 14,
   parameter int         DEPTH    = 16,
   parameter int         ADDR_W   = addr_bits(DEPTH),
   parameter int         READ_LAT = 1,
   parameter logic [1:0] DEV_ID   = DEV_ROM
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        dev_sel,
   input  logic [ADDR_W-1:0] op_addr,
   input  logic              rd_req,
   output logic              rd_valid,
   output logic [WORD_W-1:0] rd_data,
   output logic              rd_err,
   output logic              data_oe,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [WORD_W-1:0] ld_data,
   input  logic              ld_done,
   output logic              ld_err,
   output logic              ready
);

   localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);
   localparam logic [WORD_W-1:0] NOP      = WORD_W'(NOP_WORD);

   rom_state_e        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              ld_err_q, ld_err_d;
   logic              ready_q, ready_d;

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [WORD_W-1:0] mem_wdata;

   logic              ld_in_range;
   logic              rd_accept;
   logic              rd_in_range;
   logic              rd_fail;
   logic [ADDR_W-1:0] rd_idx;
   logic [WORD_W-1:0] rd_word;

   assign ld_in_range = {1'b0, ld_addr} < DEPTH_X;

   // Next state, clear counter, memory write port and load-reject pulse.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_we    = 1'b0;
      mem_waddr = cnt_q;
      mem_wdata = NOP;
      ld_err_d  = 1'b0;
      case (state_q)
         ROM_CLEAR: begin
            mem_we   = 1'b1;
            ld_err_d = ld_we;
            if (cnt_q == LAST_CNT) begin
               state_d = ROM_LOAD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         ROM_LOAD: begin
            if (ld_we) begin
               if (ld_in_range) begin
                  mem_we    = 1'b1;
                  mem_waddr = ld_addr;
                  mem_wdata = ld_data;
               end else begin
                  ld_err_d = 1'b1;
               end
            end
            if (ld_done) begin
               state_d = ROM_RUN;
            end
         end
         ROM_RUN: begin
            ld_err_d = ld_we;
         end
         default: begin
            // Unused encoding: restart the zero-fill from the beginning.
            state_d  = ROM_CLEAR;
            cnt_d    = '0;
            ld_err_d = ld_we;
         end
      endcase
      ready_d = (state_d == ROM_RUN);
   end

   // Control registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ROM_CLEAR;
         cnt_q    <= '0;
         ld_err_q <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ld_err_q <= ld_err_d;
         ready_q  <= ready_d;
      end
   end

   // Storage array write port.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset; the CLEAR state zero-fills it, which keeps it mappable to RAM.
      if (mem_we && !rst) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // Fetch decode: only selected requests count; errors answer with NOP.
   always_comb begin
      rd_accept   = rd_req && (dev_sel == DEV_ID);
      rd_in_range = {1'b0, op_addr} < DEPTH_X;
      rd_fail     = (state_q != ROM_RUN) || !rd_in_range;
      rd_idx      = rd_in_range ? op_addr : '0;
      rd_word     = (rd_accept && !rd_fail) ? mem_q[rd_idx] : NOP;
   end

   rom_read_pipe #(
      .WORD_W   (WORD_W),
      .READ_LAT (READ_LAT)
   ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rd_accept),
      .in_err    (rd_accept && rd_fail),
      .in_data   (rd_word),
      .out_valid (rd_valid),
      .out_err   (rd_err),
      .out_data  (rd_data)
   );

   assign data_oe = rd_valid;
   assign ld_err  = ld_err_q;
   assign ready   = ready_q;

endmodule
